// File: rtl/user_module_encode_search_decoder.sv
// Brute-force inverse of a 5-bit encoder: searches candidates 0..31 until E(x) matches the latched code.
// Optional nomatch flag on io_out[7] is enabled by defining USER_MODULE_DECODE_NOMATCH_EN.
module user_module_encode_search_decoder (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  logic       w_clk;
  logic       w_rst_n;
  logic       w_start;
  logic [4:0] w_code;

  assign w_clk   = io_in[0];
  assign w_rst_n = io_in[1];
  assign w_start = io_in[2];
  assign w_code  = io_in[7:3];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_cand;
  logic [4:0] r_code;
  logic [4:0] r_result;
  logic       r_busy;
  logic       r_done;
  logic [4:0] w_enc;
  logic       w_match;
  logic       w_last;

  function automatic logic [4:0] enc(input logic [4:0] x);
    logic a, b, c, d, e, t, u, v, y0, y1, y2, y3, y4;
    a  = x[0]; b = x[1]; c = x[2]; d = x[3]; e = x[4];
    t  = a ^ e;
    u  = b ^ c;
    v  = d ^ e;
    y4 = v ^ (~t & b);
    y0 = t ^ (~b & c) ^ y4;
    y1 = t ^ (~b & c) ^ b ^ (~u & d);
    y2 = ~(u ^ (~d & e));
    y3 = u ^ (~d & e) ^ d ^ (~v & t);
    return {y4, y3, y2, y1, y0};
  endfunction

  assign w_enc   = enc(r_cand);
  assign w_match = (w_enc == r_code);
  assign w_last  = (r_cand == 5'd31);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start) w_state_nxt = SEARCH;
      SEARCH:     if (w_match || w_last) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= IDLE;
      r_cand   <= 5'd0;
      r_code   <= 5'd0;
      r_result <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == SEARCH);
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_code <= w_code;
            r_cand <= 5'd0;
            r_done <= 1'b0;
          end
        end
        SEARCH: begin
          // result keeps its previous value until the search concludes
          if (w_match) begin
            r_result <= r_cand;
            r_done   <= 1'b1;
          end else if (w_last) begin
            r_result <= 5'd0;
            r_done   <= 1'b1;
          end else begin
            r_cand <= r_cand + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef USER_MODULE_DECODE_NOMATCH_EN
  logic r_nomatch;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_nomatch <= 1'b0;
    end else if ((r_state == IDLE || r_state == DONE) && w_start) begin
      r_nomatch <= 1'b0;
    end else if (r_state == SEARCH && !w_match && w_last) begin
      r_nomatch <= 1'b1;
    end
  end

  assign io_out[7] = r_nomatch;
`else
  assign io_out[7] = 1'b0;
`endif

  assign io_out[6]   = r_done;
  assign io_out[5]   = r_busy;
  assign io_out[4:0] = r_result;

endmodule

// File: tb/tb_user_module_encode_search_decoder.sv
// Bench for user_module_encode_search_decoder: transaction-level model plus directed literal checks.
module tb_user_module_encode_search_decoder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] code;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int vectors;
  int fails;

  assign io_in = {code, start, rst_n, clk};

  user_module_encode_search_decoder dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] enc(input logic [4:0] x);
    logic a, b, c, d, e, t, u, v, y0, y1, y2, y3, y4;
    a  = x[0]; b = x[1]; c = x[2]; d = x[3]; e = x[4];
    t  = a ^ e;
    u  = b ^ c;
    v  = d ^ e;
    y4 = v ^ (~t & b);
    y0 = t ^ (~b & c) ^ y4;
    y1 = t ^ (~b & c) ^ b ^ (~u & d);
    y2 = ~(u ^ (~d & e));
    y3 = u ^ (~d & e) ^ d ^ (~v & t);
    return {y4, y3, y2, y1, y0};
  endfunction

  // Lowest preimage of c; found=0 when c is outside the image of E.
  function automatic void lookup(input logic [4:0] c, output logic found,
                                 output logic [4:0] res, output int lat);
    found = 1'b0;
    res   = 5'd0;
    lat   = 32;
    for (int x = 0; x < 32; x++) begin
      if (!found && enc(5'(x)) == c) begin
        found = 1'b1;
        res   = 5'(x);
        lat   = x + 1;
      end
    end
  endfunction

  // Transaction-level model: a pending answer and a countdown to its release.
  logic       m_busy, m_done, m_nm, m_tnm, m_found;
  logic [4:0] m_res, m_tres;
  int         m_left;

  initial begin
    m_busy = 0; m_done = 0; m_nm = 0; m_tnm = 0; m_res = 0; m_tres = 0; m_left = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_nm = 0; m_res = 0; m_left = 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy = 0;
        m_done = 1;
        m_res  = m_tres;
        m_nm   = m_tnm;
      end else begin
        m_left = m_left - 1;
      end
    end else if (start) begin
      lookup(code, m_found, m_tres, m_left);
      m_tnm  = ~m_found;
      m_busy = 1;
      m_done = 0;
      m_nm   = 0;
    end
  end

  function automatic logic nm_expect(input logic nm);
`ifdef USER_MODULE_DECODE_NOMATCH_EN
    return nm;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    logic [7:0] exp_out;
    exp_out = {nm_expect(m_nm), m_done, m_busy, m_res};
    vectors++;
    if (io_out !== exp_out) begin
      fails++;
      $display("FAIL cycle_model t=%0t io_out=%h expected=%h", $time, io_out, exp_out);
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; starts a search and checks done timing and result.
  task automatic run(input logic [4:0] c, input int exp_res, input int exp_lat,
                     input int exp_nm, input bit pulse, input string name);
    start = 1'b1;
    code  = c;
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_lat; i++) begin
      chk({name, "_done_low"}, int'(io_out[6]), 0);
      code  = 5'($urandom);
      start = pulse && (i % 2 == 1) && (i < exp_lat - 1);
      tick();
    end
    start = 1'b0;
    chk({name, "_done"}, int'(io_out[6]), 1);
    chk({name, "_busy"}, int'(io_out[5]), 0);
    chk({name, "_result"}, int'(io_out[4:0]), exp_res);
    chk({name, "_nomatch"}, int'(io_out[7]), exp_nm);
  endtask

  initial begin
    logic       f;
    logic [4:0] r;
    int         l;
    logic [4:0] c;
    vectors = 0;
    fails   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    code  = 5'd0;
    #2;
    chk("reset_out", int'(io_out), 0);
    tick();
    rst_n = 1'b1;

    run(5'h04, 0, 1, 0, 1'b0, "code04");
    tick();
    run(5'h0F, 1, 2, 0, 1'b0, "code0F");
    tick();
    lookup(5'h1D, f, r, l);
    run(5'h1D, int'(r), l, 0, 1'b0, "code1D");
    tick();

    for (int v = 0; v < 32; v++) begin
      lookup(5'(v), f, r, l);
      if (!f) begin
        run(5'(v), 0, 32, int'(nm_expect(1'b1)), 1'b0, "nomatch");
        tick();
      end
    end

    c = 5'($urandom);
    lookup(c, f, r, l);
    run(c, int'(r), l, int'(nm_expect(~f)), 1'b1, "start_ignored");
    tick();

    // asynchronous reset in the middle of a search
    lookup(5'h1D, f, r, l);
    start = 1'b1;
    code  = (l > 3) ? 5'h1D : 5'h04;
    tick();
    start = 1'b0;
    if (l > 3) begin
      tick();
      chk("pre_reset_busy", int'(io_out[5]), 1);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", int'(io_out), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("no_done_after_reset", int'(io_out[6]), 0);
    run(5'h04, 0, 1, 0, 1'b0, "first_after_reset");

    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      code  = 5'($urandom);
      tick();
    end

    start = 1'b1;
    code  = 5'h0F;
    for (int i = 0; i < 60; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/user_module_encode_search_decoder.md
USER_MODULE_ENCODE_SEARCH_DECODER -- requirements
Module: user_module_encode_search_decoder

Interface
REQ-001 The block SHALL expose io_in[0]  input  1  clk, the single clock (rising edge).
REQ-002 The block SHALL expose io_in[1]  input  1  rst_n, asynchronous active-low reset.
REQ-003 The block SHALL expose io_in[2]  input  1  start, a request to decode the code word presented on io_in[7:3].
REQ-004 The block SHALL expose io_in[7:3]  input  5  code[4:0], the encoded word to invert.
REQ-005 The block SHALL expose io_out[4:0]  output  5  result[4:0], the decoded word.
REQ-006 The block SHALL expose io_out[5]  output  1  busy, high while a search is in progress.
REQ-007 The block SHALL expose io_out[6]  output  1  done, high while a completed result is held.
REQ-008 The block SHALL expose io_out[7]  output  1  nomatch, high with done when no candidate encodes to code.

Function
REQ-009 The block SHALL implement the 5-bit encode function E(x) internally, where a..e = x[0]..x[4], t=a^e, u=b^c, v=d^e.
REQ-010 E(x) SHALL be defined as: y4=v^(~t&b); y0=t^(~b&c)^y4; y1=t^(~b&c)^b^(~u&d); y2=~(u^(~d&e)); y3=u^(~d&e)^d^(~v&t).
REQ-011 The block SHALL have states IDLE, SEARCH and DONE, and reset SHALL enter IDLE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL latch code, clear the candidate counter to 0, clear done and nomatch, and enter SEARCH.
REQ-013 In SEARCH, start SHALL be ignored, and io_in[7:3] changes SHALL NOT affect the latched code.
REQ-014 Each SEARCH cycle SHALL compare E(candidate) with the latched code.
REQ-015 On a match, the block SHALL load result=candidate, set done=1, and enter DONE.
REQ-016 With no match and candidate<31, the block SHALL increment candidate and remain in SEARCH.
REQ-017 With no match at candidate=31, the block SHALL set done=1 and nomatch=1, load result=0, and enter DONE.
REQ-018 The result SHALL be the lowest x with E(x)=code.
REQ-019 done SHALL rise exactly k+1 cycles after the start-sampling edge when the match is at candidate k, and 32 cycles after it for nomatch.
REQ-020 busy SHALL equal 1 exactly in SEARCH; done and busy SHALL never be high together.
REQ-021 In DONE, result, done and nomatch SHALL hold until the next accepted start.
REQ-022 start held high continuously SHALL restart a search on the edge after each DONE entry.
REQ-023 All outputs SHALL be registered, with no combinational path from io_in to io_out.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock edge, force the state to IDLE and set result=0, busy=0, done=0, nomatch=0, candidate=0 and latched code=0.
REQ-025 Reset asserted mid-search SHALL abort the search, and no done SHALL follow the reset.
REQ-026 After rst_n rises, the first start SHALL be accepted on the first rising edge with start=1.

Configuration
REQ-027 The nomatch flag SHALL be enabled only when macro USER_MODULE_DECODE_NOMATCH_EN is defined.
REQ-028 With USER_MODULE_DECODE_NOMATCH_EN defined, io_out[7] SHALL behave per REQ-008 and REQ-017.
REQ-029 Without USER_MODULE_DECODE_NOMATCH_EN, io_out[7] SHALL be constant 0 and the nomatch register SHALL be absent.
REQ-030 Without USER_MODULE_DECODE_NOMATCH_EN, a failed search SHALL still give done=1 and result=0 after 32 cycles.

Verification
REQ-031 The bench SHALL apply start with code=0x04 -> result=0x00, done=1 one cycle after start is sampled, with busy high for 1 cycle.
REQ-032 The bench SHALL apply start with code=0x0F -> result=0x01, done=1 two cycles after start is sampled.
REQ-033 The bench SHALL apply start with code=0x1D -> result = the lowest x with E(x)=0x1D, compared against a bench model of REQ-010, with done at that x+1 cycles.
REQ-034 The bench SHALL enumerate E over 0..31, apply each value in 0..31 that is outside the image (if any) -> nomatch=1 and result=0 after 32 cycles, and repeat with USER_MODULE_DECODE_NOMATCH_EN undefined -> io_out[7]=0.
REQ-035 The bench SHALL pulse start during SEARCH while changing io_in[7:3] -> the original search completes unchanged.
REQ-036 The bench SHALL assert rst_n=0 for one cycle mid-search, asynchronously between edges -> all outputs become 0 immediately, the state is IDLE, and no done follows.
